brainhack_core: RTL

BRAINHACK_CORE -- requirements
Module: brainhack_core

---
 rtl/brainhack_core.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/brainhack_core.sv
// Brainfuck-style interpreter core: one instruction per cycle over
// external program, tape and loop-stack memories with in/out handshakes.
module brainhack_core #(
  parameter int TAPE_DATA_W  = 8,
  parameter int TAPE_ADDR_W  = 8,
  parameter int PRG_ADDR_W   = 8,
  parameter int STACK_ADDR_W = 4,
  parameter int PRG_LEN      = 255
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_run,
  input  logic [2:0]              i_prgmem_data,
  input  logic [TAPE_DATA_W-1:0]  i_tape_data,
  input  logic [PRG_ADDR_W-1:0]   i_stack_data,
  input  logic [TAPE_DATA_W-1:0]  i_in_data,
  input  logic                    i_in_valid,
  input  logic                    i_out_ready,
  output logic [PRG_ADDR_W-1:0]   o_prgmem_addr,
  output logic [TAPE_ADDR_W-1:0]  o_tape_addr,
  output logic [TAPE_DATA_W-1:0]  o_tape_data,
  output logic                    o_tape_in,
  output logic [STACK_ADDR_W-1:0] o_stack_addr,
  output logic [PRG_ADDR_W-1:0]   o_stack_data,
  output logic                    o_stack_in,
  output logic                    o_in_ready,
  output logic [TAPE_DATA_W-1:0]  o_out_data,
  output logic                    o_out_valid,
  output logic                    o_halted,
  output logic                    o_error
);
  localparam int SP_W = STACK_ADDR_W + 1;
  localparam logic [SP_W-1:0] SP_FULL =
    {1'b1, {STACK_ADDR_W{1'b0}}};
  localparam logic [PRG_ADDR_W-1:0] PC_END =
    PRG_ADDR_W'(PRG_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_SKIP, S_WAIT_IN,
    S_WAIT_OUT, S_HALT, S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    OP_OUT, OP_IN, OP_INC, OP_DEC,
    OP_RIGHT, OP_LEFT, OP_LOOP, OP_END
  } op_e;

  state_e                   state_q;
  logic [PRG_ADDR_W-1:0]    pc_q;
  logic [SP_W-1:0]          sp_q;
  logic [TAPE_ADDR_W-1:0]   ptr_q;
  logic [PRG_ADDR_W-1:0]    depth_q;
  logic [TAPE_DATA_W-1:0]   out_q;

  op_e                      op;
  logic                     at_end;
  logic                     cell_nz;
  logic                     sp_full;
  logic                     exec;
  logic [PRG_ADDR_W-1:0]    pc_p1;
  logic                     tape_we;
  logic [TAPE_DATA_W-1:0]   tape_wd;
  logic                     stack_we;
  logic [STACK_ADDR_W-1:0]  stack_a;

  assign op      = op_e'(i_prgmem_data);
  assign at_end  = (pc_q == PC_END);
  assign cell_nz = |i_tape_data;
  assign sp_full = (sp_q == SP_FULL);
  assign exec    = (state_q == S_EXEC) && !at_end;
  assign pc_p1   = pc_q + PRG_ADDR_W'(1);

  always_comb begin
    tape_we  = 1'b0;
    tape_wd  = i_tape_data + TAPE_DATA_W'(1);
    stack_we = 1'b0;
    stack_a  = sp_q[STACK_ADDR_W-1:0];
    unique case (1'b1)
      exec && (op == OP_INC): tape_we = 1'b1;
      exec && (op == OP_DEC): begin
        tape_we = 1'b1;
        tape_wd = i_tape_data - TAPE_DATA_W'(1);
      end
      exec && (op == OP_LOOP):
        stack_we = cell_nz && !sp_full;
      exec && (op == OP_END):
        stack_a = sp_q[STACK_ADDR_W-1:0]
                - STACK_ADDR_W'(1);
      state_q == S_WAIT_IN: begin
        tape_we = i_in_valid;
        tape_wd = i_in_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      sp_q    <= '0;
      ptr_q   <= '0;
      depth_q <= '0;
      out_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_HALT, S_ERROR: begin
          if (i_run) begin
            pc_q    <= '0;
            sp_q    <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (at_end) begin
            state_q <= S_HALT;
          end else begin
            unique case (op)
              OP_INC, OP_DEC: pc_q <= pc_p1;
              OP_RIGHT: begin
                ptr_q <= ptr_q + TAPE_ADDR_W'(1);
                pc_q  <= pc_p1;
              end
              OP_LEFT: begin
                ptr_q <= ptr_q - TAPE_ADDR_W'(1);
                pc_q  <= pc_p1;
              end
              OP_LOOP: begin
                if (!cell_nz) begin
                  depth_q <= PRG_ADDR_W'(1);
                  pc_q    <= pc_p1;
                  state_q <= S_SKIP;
                end else if (sp_full) begin
                  state_q <= S_ERROR;
                end else begin
                  sp_q <= sp_q + SP_W'(1);
                  pc_q <= pc_p1;
                end
              end
              OP_END: begin
                if (sp_q == '0) begin
                  state_q <= S_ERROR;
                end else if (cell_nz) begin
                  pc_q <= i_stack_data;
                end else begin
                  sp_q <= sp_q - SP_W'(1);
                  pc_q <= pc_p1;
                end
              end
              OP_OUT: begin
                out_q   <= i_tape_data;
                state_q <= S_WAIT_OUT;
              end
              OP_IN: state_q <= S_WAIT_IN;
              default: ;
            endcase
          end
        end
        S_SKIP: begin
          if (at_end) begin
            state_q <= S_ERROR;
          end else begin
            pc_q <= pc_p1;
            if (op == OP_LOOP) begin
              depth_q <= depth_q + PRG_ADDR_W'(1);
            end else if (op == OP_END) begin
              depth_q <= depth_q - PRG_ADDR_W'(1);
              if (depth_q == PRG_ADDR_W'(1)) begin
                state_q <= S_EXEC;
              end
            end
          end
        end
        S_WAIT_IN: begin
          if (i_in_valid) begin
            pc_q    <= pc_p1;
            state_q <= S_EXEC;
          end
        end
        S_WAIT_OUT: begin
          if (i_out_ready) begin
            pc_q    <= pc_p1;
            state_q <= S_EXEC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_prgmem_addr = pc_q;
  assign o_tape_addr   = ptr_q;
  assign o_tape_data   = tape_wd;
  assign o_tape_in     = tape_we;
  assign o_stack_addr  = stack_a;
  assign o_stack_data  = pc_p1;
  assign o_stack_in    = stack_we;
  assign o_in_ready    = (state_q == S_WAIT_IN);
  assign o_out_data    = out_q;
  assign o_out_valid   = (state_q == S_WAIT_OUT);
  assign o_halted      = (state_q == S_HALT);
  assign o_error       = (state_q == S_ERROR);
endmodule
